// File: rtl/seq_mul_add.sv
// Sequential shift-and-add multiply-accumulator: p = a*b + c, one multiplier bit per clock.
// Shares the divider's {acc, mq} register layout but shifts right to rebuild X = Q*Y + R.
module seq_mul_add #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   c,
    output logic [2*N-1:0] p,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  m;
    logic [N-1:0]  mq;
    logic [N:0]    acc;
    logic [N:0]    sum;
    logic [CW-1:0] count;
    logic          accept;
    logic          last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        done   = (state == DONE);
        accept = start && (state != RUN);
        last   = (state == RUN) && (count == CW'(N - 1));
    end

    // acc carries one extra bit so the carry of the partial sum survives the shift
    assign sum = acc + (mq[0] ? {1'b0, m} : {(N + 1){1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= '0;
            acc   <= '0;
            mq    <= '0;
            count <= '0;
            p     <= '0;
        end else if (accept) begin
            m     <= a;
            acc   <= {1'b0, c};
            mq    <= b;
            count <= '0;
        end else if (state == RUN) begin
            acc   <= {1'b0, sum[N:1]};
            mq    <= {sum[0], mq[N-1:1]};
            count <= count + CW'(1);
            if (last) begin
                p <= {sum, mq[N-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_add.sv
// Bench for seq_mul_add: directed and random operations checked against plain a*b+c arithmetic,
// plus latency, handshake, back-to-back and asynchronous-reset behaviour.
module tb_seq_mul_add;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic [2*N-1:0] p;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    seq_mul_add #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .p     (p),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents operands with start for exactly one accept edge; returns in the first busy cycle.
    task automatic applyStimulus(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic [N-1:0] ci);
        @(negedge clk);
        a     = ai;
        b     = bi;
        c     = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in the cycle after acceptance; optionally hammers start with fresh operands while busy.
    task automatic waitDone(input string tag, input int expected_p, input bit jam);
        int             lat;
        int             busy_cycles;
        logic [2*N-1:0] held;
        lat         = 1;
        busy_cycles = 0;
        held        = p;
        while (!done && lat < 4 * N) begin
            if (busy) busy_cycles++;
            checkOutput({tag, " p held"}, p, held);
            if (jam) begin
                start = busy;
                a     = N'($urandom_range(0, 15));
                b     = N'($urandom_range(0, 15));
                c     = N'($urandom_range(0, 15));
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput({tag, " latency"}, lat, N + 1);
        checkOutput({tag, " busy cycles"}, busy_cycles, N);
        checkOutput({tag, " busy in done"}, busy, 1'b0);
        checkOutput({tag, " p"}, p, expected_p);
    endtask

    initial begin
        int done_seen;
        int ra;
        int rb;
        int rc;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset p", p, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        rst_n = 1'b1;

        applyStimulus(4'd3, 4'd5, 4'd2);
        waitDone("basic", 17, 1'b0);
        applyStimulus(4'd15, 4'd15, 4'd15);
        waitDone("max", 240, 1'b0);
        applyStimulus(4'd0, 4'd9, 4'd7);
        waitDone("zero a", 7, 1'b0);
        applyStimulus(4'd9, 4'd0, 4'd0);
        waitDone("zero b", 0, 1'b0);

        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                applyStimulus(N'(x / y), N'(y), N'(x % y));
                waitDone("recompose", x, 1'b0);
            end
        end

        applyStimulus(4'd6, 4'd7, 4'd1);
        waitDone("ignore start", 43, 1'b1);
        @(negedge clk);
        checkOutput("no restart busy", busy, 0);
        checkOutput("no restart done", done, 0);

        applyStimulus(4'd1, 4'd1, 4'd0);
        waitDone("b2b first", 1, 1'b0);
        a     = 4'd2;
        b     = 4'd3;
        c     = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("b2b second", 10, 1'b0);

        applyStimulus(4'd5, 4'd5, 4'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset p", p, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset done", done, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (2 * N + 2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("no done after reset", done_seen, 0);
        checkOutput("p after reset", p, 0);
        applyStimulus(4'd4, 4'd4, 4'd0);
        waitDone("after reset", 16, 1'b0);

        repeat (40) begin
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            rc = $urandom_range(0, 15);
            applyStimulus(N'(ra), N'(rb), N'(rc));
            waitDone("random", ra * rb + rc, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
